// File: rtl/demux32_8way_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : demux32_8way_buf_pkg
// Description : Shared constants, lane state type and lane-slice macro for
//               the 1-to-8 registered result distributor.
// Contents    : DEMUX_DATA_W - data word width
//               DEMUX_SEL_W  - lane-select width
//               DEMUX_LANES  - number of lanes (2**DEMUX_SEL_W)
//               lane_state_t - per-lane holding-register state
//               `DEMUX_LANE_SLICE(i) - part-select of lane i in a packed
//                                      LANES*DATA_W bus (uses DATA_W in scope)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef DEMUX32_8WAY_BUF_LANE_SLICE
`define DEMUX32_8WAY_BUF_LANE_SLICE
`define DEMUX_LANE_SLICE(i) ((i)*DATA_W) +: DATA_W
`endif

package demux32_8way_buf_pkg;

    localparam int DEMUX_DATA_W = 32;
    localparam int DEMUX_SEL_W  = 3;
    localparam int DEMUX_LANES  = 2 ** DEMUX_SEL_W;

    // A lane either holds a word for its consumer or is free.
    typedef enum logic [0:0] {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage : demux32_8way_buf_pkg

`default_nettype wire

// File: rtl/demux32_8way_buf_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane_reg
// Description : One-entry holding register for a single distributor lane.
//               Loads a word on i_load, presents it with o_valid until the
//               consumer takes it with i_ready. A load in the same cycle as a
//               drain replaces the word without a bubble.
// Ports       : clk        - clock, rising edge
//               i_rst_n    - asynchronous active-low clear
//               i_load     - write i_data into this lane on the next edge
//               i_data     - word to load
//               i_ready    - consumer takes the held word this cycle
//               o_valid    - lane holds a word
//               o_data     - held word (keeps last value after a drain)
//               o_can_load - lane is free now or is being drained this cycle
// Revision    : 1.0 - initial release
// ============================================================================

module demux_lane_reg
    import demux32_8way_buf_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_can_load
);

    lane_state_t       r_state;
    lane_state_t       w_state_next;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LANE_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load always wins over a drain: the old word is consumed and the new
    // one takes its place, so FULL persists.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LANE_EMPTY: begin
                if (i_load) begin
                    w_state_next = LANE_FULL;
                end
            end
            LANE_FULL: begin
                if (i_load) begin
                    w_state_next = LANE_FULL;
                end else if (i_ready) begin
                    w_state_next = LANE_EMPTY;
                end
            end
            default: w_state_next = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid    = (r_state == LANE_FULL);
    assign o_data     = r_data;
    assign o_can_load = (r_state == LANE_EMPTY) | i_ready;

endmodule : demux_lane_reg

`default_nettype wire

// File: rtl/demux32_8way_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux32_8way_buf
// Description : Registered 1-to-8 distributor for 32-bit execution-core
//               results. One word per cycle under valid/ready is routed to
//               the lane selected by in_sel, or to every lane on in_bcast.
//               Each lane has its own one-entry holding register, so a
//               stalled consumer only blocks traffic aimed at its lane.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-low reset
//               in_valid  - producer presents a word
//               in_ready  - word accepted this cycle (no path from in_valid)
//               in_data   - word to distribute
//               in_sel    - destination lane (ignored on broadcast)
//               in_bcast  - write the word to all lanes
//               out_valid - per-lane word present
//               out_ready - per-lane consumer ready
//               out_data  - lane i data at [i*DATA_W +: DATA_W]
//               busy      - any lane holds a word
// Revision    : 1.0 - initial release
// ============================================================================

module demux32_8way_buf
    import demux32_8way_buf_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W,
    parameter int SEL_W  = DEMUX_SEL_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_bcast,
    output logic [(2**SEL_W)-1:0]         out_valid,
    input  logic [(2**SEL_W)-1:0]         out_ready,
    output logic [(2**SEL_W)*DATA_W-1:0]  out_data,
    output logic                          busy
);

    localparam int LANES = 2 ** SEL_W;

    logic [LANES-1:0] w_onehot;
    logic [LANES-1:0] w_can_load;
    logic [LANES-1:0] w_load;
    logic             w_accept;

    always_comb begin
        w_onehot         = '0;
        w_onehot[in_sel] = 1'b1;
    end

    // Broadcast is all-or-nothing: every lane must be able to take the word
    // this cycle, otherwise nothing is accepted.
    assign in_ready = in_bcast ? (&w_can_load) : w_can_load[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_load   = {LANES{w_accept}} & ({LANES{in_bcast}} | w_onehot);
    assign busy     = |out_valid;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            demux_lane_reg #(
                .DATA_W (DATA_W)
            ) u_lane (
                .clk        (clk),
                .i_rst_n    (reset),
                .i_load     (w_load[gi]),
                .i_data     (in_data),
                .i_ready    (out_ready[gi]),
                .o_valid    (out_valid[gi]),
                .o_data     (out_data[`DEMUX_LANE_SLICE(gi)]),
                .o_can_load (w_can_load[gi])
            );
        end
    endgenerate

endmodule : demux32_8way_buf

`default_nettype wire
